imem_fetch_port: RTL and testbench

//  Parametrised instruction memory with a synchronous-read, valid/ready fetch interface.

---
 rtl/imem_fetch_port.sv | 153 +++++++++++++++
 tb/tb_imem_fetch_port.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_port.sv
// imem_fetch_port: synchronous-read instruction memory behind a valid/ready
// fetch port. A fetch accepted in cycle N is in the read register in cycle
// N+1. From there it moves into a 2-entry response FIFO, or it bypasses the
// FIFO when the FIFO is empty. A credit check keeps responses from being
// dropped. Misaligned and out-of-range fetches return ERR_WORD with rsp_err=1.
//
// Optional feature: define IMEM_PROG_LOAD_EN to add a program-load write port.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready   fetch handshake; req_addr is a byte address
//   rsp_valid/rsp_ready   response handshake; rsp_data / rsp_err payload
//   flush                 drop in-flight and buffered responses (redirect)
//   ld_we/ld_addr/ld_data program-load write port (IMEM_PROG_LOAD_EN only)
module imem_fetch_port #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       DEPTH     = 256,
  parameter string             INIT_FILE = "",
  parameter logic [DATA_W-1:0] ERR_WORD  = DATA_W'(32'h00000013)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  input  logic              flush
`ifdef IMEM_PROG_LOAD_EN
  ,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data
`endif
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned OFF_W = (BYTES > 1) ? $clog2(BYTES) : 0;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned ENT_W = DATA_W + 1;

  // Faults on non-zero offset bits or a word index past the array end.
  function automatic logic addr_err(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] mask;
    logic [ADDR_W-1:0] idx;
    mask = ADDR_W'((64'd1 << OFF_W) - 64'd1);
    idx  = a >> OFF_W;
    return ((a & mask) != '0) || (64'(idx) >= 64'(DEPTH));
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return IDX_W'(a >> OFF_W);
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];

`ifdef IMEM_PROG_LOAD_EN
  // Faulting load addresses are dropped. The fetch path samples mem
  // before this edge, so a same-cycle read returns the old word.
  always_ff @(posedge clk) begin
    if (ld_we && !addr_err(ld_addr)) mem[word_idx(ld_addr)] <= ld_data;
  end
`endif

  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q,  rd_data_d;
  logic              rd_err_q,   rd_err_d;
  logic [ENT_W-1:0]  fifo_q [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q,  count_d;

  logic              req_err;
  logic              acc;
  logic              pop;
  logic              pop_fifo;
  logic              push;
  logic [ENT_W-1:0]  head;

  // Handshakes, response head mux and next-state logic.
  always_comb begin
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    rd_err_d   = rd_err_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    req_err   = addr_err(req_addr);
    head      = (count_q != 2'd0) ? fifo_q[rd_ptr_q] : {rd_err_q, rd_data_q};
    rsp_valid = rd_valid_q || (count_q != 2'd0);
    rsp_err   = head[ENT_W-1];
    rsp_data  = head[DATA_W-1:0];

    // Flush frees every credit on the coming edge, so the redirect target
    // can be accepted in the flush cycle itself.
    req_ready = flush || (({1'b0, count_q} + 3'(rd_valid_q)) < 3'd2);
    acc       = req_valid && req_ready;
    pop       = rsp_valid && rsp_ready;
    pop_fifo  = pop && (count_q != 2'd0);
    // The read-register word goes into the FIFO unless it is consumed
    // directly through the bypass.
    push      = rd_valid_q && !(pop && (count_q == 2'd0));

    if (push)     wr_ptr_d = ~wr_ptr_q;
    if (pop_fifo) rd_ptr_d = ~rd_ptr_q;
    unique case ({push, pop_fifo})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end

    if (acc) begin
      rd_valid_d = 1'b1;
      rd_err_d   = req_err;
      rd_data_d  = req_err ? ERR_WORD : mem[word_idx(req_addr)];
    end
  end

  // Control and read register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_err_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_err_q   <= rd_err_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // FIFO storage. Entries are only read while the count covers them.
  always_ff @(posedge clk) begin
    if (push && !flush) fifo_q[wr_ptr_q] <= {rd_err_q, rd_data_q};
  end

endmodule

// File: tb/tb_imem_fetch_port.sv
module tb_imem_fetch_port;

  localparam int unsigned DEPTH = 256;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr  = '0;
  logic        rsp_ready = 1'b0;
  logic        flush     = 1'b0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
`ifdef IMEM_PROG_LOAD_EN
  logic        ld_we   = 1'b0;
  logic [31:0] ld_addr = '0;
  logic [31:0] ld_data = '0;
`endif

  imem_fetch_port dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .flush     (flush)
`ifdef IMEM_PROG_LOAD_EN
    ,
    .ld_we     (ld_we),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int n_acc = 0;

  // Reference: the ordered list of responses still owed, each with the
  // cycle from which it may appear.
  typedef struct {
    logic [31:0] data;
    logic        err;
    int          rdy;
  } exp_t;
  exp_t q[$];

  logic [31:0] mem_m [DEPTH];

  typedef struct {
    logic [31:0] addr;
    logic        err;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic ref_err(input logic [31:0] a);
    return ((a % 32'd4) != 32'd0) || ((a / 32'd4) >= 32'(DEPTH));
  endfunction

  function automatic logic [31:0] ref_data(input logic [31:0] a);
    if (ref_err(a)) return 32'h00000013;
    return mem_m[a / 32'd4];
  endfunction

  // Called between edges: checks outputs against the reference, then
  // applies this cycle's handshakes to it.
  task automatic model_cycle();
    logic vis;
    logic exp_rdy;
    if (!rst_n) begin
      q.delete();
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      return;
    end
    exp_rdy = flush || (q.size() < 2);
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    vis = (q.size() > 0) && (q[0].rdy <= cyc);
    chk("rsp_valid", 32'(rsp_valid), 32'(vis));
    if (vis) begin
      chk("rsp_data", rsp_data, q[0].data);
      chk("rsp_err", 32'(rsp_err), 32'(q[0].err));
      if (rsp_ready) void'(q.pop_front());
    end
    if (flush) q.delete();
    if (req_valid && exp_rdy) begin
      n_acc++;
      q.push_back('{ref_data(req_addr), ref_err(req_addr), cyc + 1});
    end
`ifdef IMEM_PROG_LOAD_EN
    if (ld_we && !ref_err(ld_addr)) mem_m[ld_addr / 32'd4] = ld_data;
`endif
    cyc++;
  endtask

  task automatic step();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [31:0] a);
    req_valid = 1'b1;
    req_addr  = a;
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    int          acc0;
    int          r;
    logic [31:0] old_word;

    for (int i = 0; i < DEPTH; i++) mem_m[i] = $urandom();

    tbl[0] = '{32'h0000_0000, 1'b0};
    tbl[1] = '{32'h0000_0004, 1'b0};
    tbl[2] = '{32'h0000_0008, 1'b0};
    tbl[3] = '{32'h0000_0006, 1'b1};
    tbl[4] = '{32'h0000_0001, 1'b1};
    tbl[5] = '{32'h0000_03FC, 1'b0};
    tbl[6] = '{32'h0000_0400, 1'b1};
    tbl[7] = '{32'hFFFF_FFFC, 1'b1};
    tbl[8] = '{32'h0000_0040, 1'b0};
    tbl[9] = '{32'h0000_03FF, 1'b1};

    #2;
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    chk("reset_rsp_data", rsp_data, 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd1);

`ifdef IMEM_PROG_LOAD_EN
    for (int i = 0; i < DEPTH; i++) begin
      ld_we   = 1'b1;
      ld_addr = 32'(i * 4);
      ld_data = mem_m[i];
      @(posedge clk);
      #1;
    end
    ld_we = 1'b0;
`else
    for (int i = 0; i < DEPTH; i++) dut.mem[i] = mem_m[i];
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Back-to-back fetches with the response side always ready.
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_addr  = 32'h0;
    step();
    chk("b2b_first_valid", 32'(rsp_valid), 32'd1);
    chk("b2b_first_data", rsp_data, mem_m[0]);
    req_addr = 32'h4;
    step();
    req_addr = 32'h8;
    step();
    req_valid = 1'b0;
    step();
    step();

    // Single-fetch vectors covering alignment and range boundaries.
    for (int i = 0; i < 10; i++) begin
      req(tbl[i].addr);
      chk("vec_valid", 32'(rsp_valid), 32'd1);
      chk("vec_err", 32'(rsp_err), 32'(tbl[i].err));
      if (tbl[i].err) chk("vec_data", rsp_data, 32'h00000013);
      else            chk("vec_data", rsp_data, mem_m[tbl[i].addr / 32'd4]);
      step();
    end

    // Backpressure: three fetches offered, two credits available.
    rsp_ready = 1'b0;
    acc0 = n_acc;
    for (int k = 0; k < 3; k++) begin
      req_valid = 1'b1;
      req_addr  = 32'(32'h10 + 4 * k);
      step();
    end
    req_valid = 1'b0;
    chk("bp_accepted", 32'(n_acc - acc0), 32'd2);
    chk("bp_req_ready", 32'(req_ready), 32'd0);
    chk("bp_head_data", rsp_data, mem_m[4]);
    step();
    chk("bp_head_held", rsp_data, mem_m[4]);
    rsp_ready = 1'b1;
    step();
    step();
    chk("bp_drained_ready", 32'(req_ready), 32'd1);
    chk("bp_drained_valid", 32'(rsp_valid), 32'd0);

    // Flush with two buffered responses and a same-cycle redirect fetch.
    rsp_ready = 1'b0;
    req(32'h20);
    req(32'h24);
    step();
    flush     = 1'b1;
    req_valid = 1'b1;
    req_addr  = 32'h40;
    #1;
    chk("flush_req_ready", 32'(req_ready), 32'd1);
    step();
    flush     = 1'b0;
    req_valid = 1'b0;
    chk("flush_next_valid", 32'(rsp_valid), 32'd1);
    chk("flush_next_data", rsp_data, mem_m[16]);
    chk("flush_next_err", 32'(rsp_err), 32'd0);
    rsp_ready = 1'b1;
    step();
    step();

    // Asynchronous reset with two responses buffered.
    rsp_ready = 1'b0;
    req(32'h28);
    req(32'h2C);
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    q.delete();
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    req(32'h30);
    chk("midrst_first_valid", 32'(rsp_valid), 32'd1);
    chk("midrst_first_data", rsp_data, mem_m[12]);
    step();

`ifdef IMEM_PROG_LOAD_EN
    // Same-cycle load and fetch of one word returns the old contents.
    old_word  = mem_m[4];
    ld_we     = 1'b1;
    ld_addr   = 32'h10;
    ld_data   = 32'hDEADBEEF;
    req(32'h10);
    ld_we = 1'b0;
    chk("ld_old_word", rsp_data, old_word);
    step();
    req(32'h10);
    chk("ld_new_word", rsp_data, 32'hDEADBEEF);
    step();
`else
    old_word = '0;
`endif

    // Random traffic against the reference.
    for (int n = 0; n < 800; n++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      r = int'($urandom_range(0, 9));
      if (r < 7)       req_addr = 32'($urandom_range(0, DEPTH - 1) * 4);
      else if (r == 7) req_addr = 32'($urandom_range(0, DEPTH - 1) * 4) | 32'($urandom_range(1, 3));
      else if (r == 8) req_addr = 32'(($urandom_range(0, 1000) + DEPTH) * 4);
      else             req_addr = 32'hFFFF_FFFC;
      rsp_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      step();
    end
    req_valid = 1'b0;
    flush     = 1'b0;
    rsp_ready = 1'b1;
    for (int n = 0; n < 4; n++) step();
    chk("final_idle_valid", 32'(rsp_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
